// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue/response stage.
package alu_pkg;

  localparam int unsigned OPND_W = 3;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned RES_W  = 8;
  localparam int unsigned FLAG_W = 4;
  localparam int unsigned CMD_W  = 2 * OPND_W + OP_W;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_MUL  = 3'b010,
    OP_DIV  = 3'b011,
    OP_ASHR = 3'b100,
    OP_ASHL = 3'b101,
    OP_BSHR = 3'b110,
    OP_BSHL = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic carry;
    logic zero;
    logic overflow;
    logic underflow;
  } alu_flags_t;

  typedef struct packed {
    logic [OPND_W-1:0] a;
    logic [OPND_W-1:0] b;
    alu_op_e           op;
  } alu_cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } issue_state_e;

  localparam logic [RES_W-1:0] DIV0_RESULT = 8'hFF;

  // True when the operands presented to the ALU are a division by zero.
  function automatic logic is_div0(input logic [OP_W-1:0] op, input logic [OPND_W-1:0] b);
    return (op == OP_DIV) && (b == '0);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO: DEPTH entries of CMD_W bits, registered count, fall-through head.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  logic [CMD_W-1:0]               wr_data,
  input  logic                           pop,
  output logic [CMD_W-1:0]               rd_data_c,
  output logic                           full_c,
  output logic                           empty_c,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [CMD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full_c    = (count == CNT_W'(DEPTH));
  assign empty_c   = (count == '0);
  assign do_push   = push && !full_c;
  assign do_pop    = pop && !empty_c;
  assign rd_data_c = mem[rd_ptr];

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two; count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue/response stage isolating the combinational ALU between register stages.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [OPND_W-1:0]              cmd_a,
  input  logic [OPND_W-1:0]              cmd_b,
  input  logic [OP_W-1:0]                cmd_op,
  output logic [OPND_W-1:0]              alu_a,
  output logic [OPND_W-1:0]              alu_b,
  output logic [OP_W-1:0]                alu_opcode,
  input  logic [RES_W-1:0]               alu_result,
  input  logic                           alu_carry,
  input  logic                           alu_zero,
  input  logic                           alu_overflow,
  input  logic                           alu_underflow,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [RES_W-1:0]               rsp_result,
  output logic [FLAG_W-1:0]              rsp_flags,
  output logic                           rsp_div0,
  output logic [$clog2(DEPTH+1)-1:0]     fifo_count
);

  issue_state_e     state;
  alu_cmd_t         cmd_in;
  alu_cmd_t         head;
  logic [CMD_W-1:0] head_raw;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  alu_flags_t       flags_in;

  assign cmd_in    = '{a: cmd_a, b: cmd_b, op: alu_op_e'(cmd_op)};
  assign head      = alu_cmd_t'(head_raw);
  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && cmd_ready;
  // Pop whenever the operand registers are free: idle, or the pending response is being taken.
  assign pop       = !fifo_empty && ((state == IDLE) || ((state == RESP) && rsp_ready));
  assign flags_in  = '{carry: alu_carry, zero: alu_zero,
                       overflow: alu_overflow, underflow: alu_underflow};

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .wr_data   (CMD_W'(cmd_in)),
    .pop       (pop),
    .rd_data_c (head_raw),
    .full_c    (fifo_full),
    .empty_c   (fifo_empty),
    .count     (fifo_count)
  );

  // Issue FSM: load operands, capture the settled ALU outputs, hold the response until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_div0   <= 1'b0;
    end else begin
      if (pop) begin
        alu_a      <= head.a;
        alu_b      <= head.b;
        alu_opcode <= head.op;
      end
      case (state)
        IDLE: begin
          if (!fifo_empty) state <= EXEC;
        end
        EXEC: begin
          if (is_div0(alu_opcode, alu_b)) begin
            rsp_result <= DIV0_RESULT;
            rsp_flags  <= '0;
            rsp_div0   <= 1'b1;
          end else begin
            rsp_result <= alu_result;
            rsp_flags  <= flags_in;
            rsp_div0   <= 1'b0;
          end
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= fifo_empty ? IDLE : EXEC;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage with a behavioural ALU and reference model.
module tb_alu_issue_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_a, cmd_b, cmd_op;
  logic [2:0] alu_a, alu_b, alu_opcode;
  logic [7:0] alu_result;
  logic       alu_carry, alu_zero, alu_overflow, alu_underflow;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_result;
  logic [3:0] rsp_flags;
  logic       rsp_div0;
  logic [2:0] fifo_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [12:0] exp_q [$];
  int          hs_q  [$];

  alu_issue_stage #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow), .alu_underflow(alu_underflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_div0(rsp_div0),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Behavioural ALU: returns {result[7:0], carry, zero, overflow, underflow}.
  function automatic logic [11:0] alu_fn(input logic [2:0] a, input logic [2:0] b, input logic [2:0] op);
    int ia, ib, r;
    logic c, o, u;
    logic [7:0] res;
    ia = int'(a); ib = int'(b); c = 1'b0; o = 1'b0; u = 1'b0;
    case (op)
      3'd0: r = ia + ib;
      3'd1: begin r = ia - ib; c = (ia < ib); u = (ia < ib); end
      3'd2: begin r = ia * ib; o = (r > 7); end
      3'd3: r = (ib == 0) ? 0 : ia / ib;
      3'd4: r = ia / 2;
      3'd5: begin r = ia * 2; o = (r > 7); end
      3'd6: r = ib / 2;
      default: begin r = ib * 2; o = (r > 7); end
    endcase
    res = r[7:0];
    return {res, c, (res == 8'h00), o, u};
  endfunction

  // Reference response: {result[7:0], flags[3:0], div0}.
  function automatic logic [12:0] expect_fn(input logic [2:0] a, input logic [2:0] b, input logic [2:0] op);
    if (op == 3'd3 && b == 3'd0) return {8'hFF, 4'b0000, 1'b1};
    return {alu_fn(a, b, op), 1'b0};
  endfunction

  // External combinational ALU driven by the stage's registered operands.
  always_comb begin
    logic [11:0] o;
    o = alu_fn(alu_a, alu_b, alu_opcode);
    {alu_result, alu_carry, alu_zero, alu_overflow, alu_underflow} = o;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: record accepted commands, pop and compare responses, check holding behaviour.
  logic       hold_prev = 1'b0;
  logic [7:0] p_res;
  logic [3:0] p_fl;
  logic       p_d;
  logic [8:0] p_ops;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_prev = 1'b0;
    end else begin
      chk("count_bound", 32'(fifo_count <= 3'd4), 32'd1);
      if (cmd_valid && cmd_ready) exp_q.push_back(expect_fn(cmd_a, cmd_b, cmd_op));
      if (hold_prev)
        chk("rsp_hold", {rsp_valid, rsp_result, rsp_flags, rsp_div0, alu_a, alu_b, alu_opcode},
            {1'b1, p_res, p_fl, p_d, p_ops});
      if (rsp_valid && rsp_ready) begin
        hs_q.push_back(cyc);
        if (exp_q.size() == 0) chk("unexpected_rsp", {rsp_result, rsp_flags, rsp_div0}, 32'h1FFF_FFFF);
        else chk("rsp_data", {rsp_result, rsp_flags, rsp_div0}, 32'(exp_q.pop_front()));
      end
      hold_prev = rsp_valid && !rsp_ready;
      p_res = rsp_result; p_fl = rsp_flags; p_d = rsp_div0;
      p_ops = {alu_a, alu_b, alu_opcode};
    end
  end

  // Offer one command (called at posedge+1); returns at posedge+1 after the accepting edge.
  task automatic send(input logic [2:0] a, input logic [2:0] b, input logic [2:0] op);
    bit ok;
    ok = 1'b0;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Single command into an idle stage; checks latency and fixed expected values.
  task automatic directed(input logic [2:0] a, input logic [2:0] b, input logic [2:0] op,
                          input logic [7:0] res, input logic [3:0] fl, input logic d);
    send(a, b, op);
    @(negedge clk); chk("lat_edge0", 32'(rsp_valid), 32'd0);
    @(negedge clk); chk("lat_edge1", 32'(rsp_valid), 32'd0);
    @(negedge clk); chk("lat_edge2", 32'(rsp_valid), 32'd1);
    chk("directed_val", {rsp_result, rsp_flags, rsp_div0}, {res, fl, d});
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !rsp_valid && fifo_count == 0) begin ok = 1'b1; break; end
    end
    if (!ok) chk("drain_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    int sent, nvalid;
    bit take, done;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; rsp_ready = 1'b0;
    #23;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_outs", {alu_a, alu_b, alu_opcode, rsp_result, rsp_flags, rsp_div0}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed arithmetic with latency checks
    rsp_ready = 1'b1;
    directed(3'd5, 3'd3, 3'd0, 8'h08, 4'b0000, 1'b0);
    directed(3'd2, 3'd5, 3'd1, 8'hFD, 4'b1001, 1'b0);
    directed(3'd6, 3'd0, 3'd3, 8'hFF, 4'b0000, 1'b1);
    directed(3'd6, 3'd3, 3'd3, 8'h02, 4'b0000, 1'b0);
    wait_idle();

    // Backpressure: five commands fill the response register plus the FIFO
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) chk("bp_ready_before5", 32'(cmd_ready), 32'd1);
      send(3'(i + 1), 3'(7 - i), 3'(i));
    end
    chk("bp_ready_after5", 32'(cmd_ready), 32'd0);
    chk("bp_count_full", 32'(fifo_count), 32'd4);
    repeat (4) @(posedge clk);
    #1;
    hs_q.delete();
    rsp_ready = 1'b1;
    for (int i = 0; i < 40 && hs_q.size() < 5; i++) @(negedge clk);
    chk("bp_rsp_count", 32'(hs_q.size()), 32'd5);
    for (int i = 1; i < hs_q.size(); i++) chk("bp_spacing", 32'(hs_q[i] - hs_q[i-1]), 32'd2);
    wait_idle();

    // Reset during EXEC with three commands queued
    rsp_ready = 1'b0;
    send(3'd1, 3'd1, 3'd0);
    for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) send(3'(i), 3'(i + 2), 3'd2);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("pre_rst_count", 32'(fifo_count), 32'd3);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_count", 32'(fifo_count), 32'd0);
    chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
    chk("mid_rst_result", 32'(rsp_result), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    rsp_ready = 1'b1;
    nvalid = 0;
    repeat (10) begin @(negedge clk); if (rsp_valid) nvalid++; end
    chk("no_stale_rsp", 32'(nvalid), 32'd0);
    @(posedge clk); #1;

    // Random stream with toggling valid and ready
    sent = 0; done = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      take = cmd_valid && cmd_ready;
      @(posedge clk); #1;
      if (take) begin sent++; cmd_valid = 1'b0; end
      if (sent < 12 && !cmd_valid) begin
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_a = 3'($urandom_range(0, 7));
        cmd_b = 3'($urandom_range(0, 7));
        cmd_op = 3'($urandom_range(0, 7));
      end
      rsp_ready = 1'($urandom_range(0, 1));
      if (sent == 12 && exp_q.size() == 0 && !rsp_valid) begin done = 1'b1; break; end
    end
    chk("random_done", 32'(done), 32'd1);
    chk("random_sent", 32'(sent), 32'd12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Registered issue/response stage wrapped around the combinational 8-bit ALU.
- Upstream: accepts operation commands (A, B, OPCODE) on a valid/ready handshake and buffers them in a small FIFO.
- Toward the ALU: issues one command at a time on registered operand ports.
- Downstream: captures the ALU's RESULT and flags into a held response register, presented on a second valid/ready handshake.

This isolates the ALU's combinational path between two register stages.

## Interface
- DEPTH, 4, command FIFO depth; power of two, ≥2
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept (count < DEPTH)
- cmd_a, cmd_b  in  3 each  operands
- cmd_op  in  3  opcode (000 add, 001 sub, 010 mul, 011 div, 100 A>>1, 101 A<<1, 110 B>>1, 111 B<<1)
- alu_a, alu_b, alu_opcode  out  3 each  registered operands to ALU
- alu_result  in  8  ALU RESULT
- alu_carry, alu_zero, alu_overflow, alu_underflow  in  1 each  ALU flags
- rsp_valid  out  1  response held
- rsp_ready  in  1  downstream accepts
- rsp_result  out  8  captured result
- rsp_flags  out  4  {carry, zero, overflow, underflow}
- rsp_div0  out  1  divide-by-zero marker
- fifo_count  out  $clog2(DEPTH+1)  occupancy

## Operation
- Push: cmd_valid && cmd_ready writes {a,b,op} at the tail.
- FSM states and transitions:
  - IDLE: if FIFO non-empty, pop head into alu_a/alu_b/alu_opcode, go to EXEC.
  - EXEC: ALU settles on registered operands. At the edge, capture alu_result and flags into the response registers, set rsp_valid, go to RESP.
  - RESP: hold all rsp_* stable while rsp_valid && !rsp_ready. On rsp_ready:
    - If FIFO non-empty: pop the next command into the operand registers, go to EXEC.
    - Otherwise: clear rsp_valid, go to IDLE.
- Divide-by-zero: if the captured opcode is 011 and alu_b == 0:
  - rsp_result = 8'hFF, rsp_flags = 4'b0000, rsp_div0 = 1.
  - In every other case rsp_div0 = 0 and the ALU outputs pass through unchanged.
- Operand registers hold their last value outside EXEC. The ALU inputs never toggle while a response is pending.
- Push and pop in the same cycle are both performed. fifo_count is unchanged; tail and head pointers advance independently and wrap modulo DEPTH.
- cmd_ready depends only on fifo_count; it has no combinational path from rsp_ready.
- Reset (asynchronous, any state, including mid-EXEC or RESP):
  - FIFO is emptied, pointers = 0, state = IDLE.
  - All outputs = 0, except cmd_ready = 1.
  - An in-flight command is discarded.

## Timing
- Latency: a command accepted at edge N into an empty FIFO with state IDLE is loaded to the ALU at edge N+1 and appears with rsp_valid = 1 after edge N+2.
- Throughput with rsp_ready held high: one response every 2 cycles.
- rsp_valid, once asserted, stays high with stable data until the handshake completes.
- All outputs are registered, except cmd_ready (decode of fifo_count).

## Structure
- alu_pkg:
  - alu_op_e opcode enum (OP_ADD … OP_BSHL)
  - alu_flags_t packed struct {carry, zero, overflow, underflow}
  - issue_state_e {IDLE, EXEC, RESP}
  - DIV0_RESULT = 8'hFF
- Sub-module alu_cmd_fifo:
  - Parameterised DEPTH, 9-bit entries.
  - push/pop/full/empty/count interface.
  - Same clk/rst_n.

## Test plan
- Add: A=5, B=3, op 000, rsp_ready=1 → rsp_valid exactly 2 cycles after acceptance, rsp_result=8'h08, flags=0000, div0=0.
- Subtract: A=2, B=5, op 001 → rsp_result=8'hFD, carry=1, underflow=1, div0=0.
- Divide by zero: A=6, B=0, op 011 → rsp_result=8'hFF, flags=0000, div0=1. Follow with A=6, B=3, op 011 → 8'h02, div0=0.
- Backpressure: hold rsp_ready=0 and push 5 commands (DEPTH=4):
  - cmd_ready falls after the 5th accepted command (4 queued plus 1 in the response register).
  - rsp_* stays stable.
  - Release rsp_ready → all 5 responses arrive in order, every 2nd cycle.
- Wrap and simultaneous push/pop: stream 12 random commands with cmd_valid and rsp_ready both toggling randomly → responses match a reference model in order; fifo_count never exceeds 4.
- Reset mid-operation: assert rst_n=0 during EXEC with 3 commands queued → immediately rsp_valid=0, fifo_count=0, cmd_ready=1; after release, no stale responses appear.
